fu_div_issue: RTL and testbench
===============================

FU_DIV_ISSUE -- requirements
Module: fu_div_issue

Interface
REQ-001 SHALL have parameter PHYS_REG_BITS, default 6, physical destination register tag width.
REQ-002 SHALL have parameter ROB_IDX_BITS, default 5, ROB index width.
REQ-003 SHALL have parameter DEPTH, default 4 (power of 2), instruction queue entries.
REQ-004 SHALL have ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; discard all queued and in-flight ops.
- in_valid  in  1  issue request.
- in_ready  out  1  queue can accept this cycle.
- in_rs1_v  in  32  dividend.
- in_rs2_v  in  32  divisor.
- in_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_pd  in  PHYS_REG_BITS  destination tag.
- in_rob_idx  in  ROB_IDX_BITS  ROB index.
- div_start  out  1  one-cycle start pulse to the sequential divider.
- div_a  out  33  extended dividend.
- div_b  out  33  extended divisor.
- div_complete  in  1  divider result ready.
- div_quotient  in  33  divider quotient.
- div_remainder  in  33  divider remainder.
- cdb_valid  out  1  result broadcast valid.
- cdb_ready  in  1  CDB accepts the broadcast.
- cdb_pd  out  PHYS_REG_BITS  result tag.
- cdb_rob_idx  out  ROB_IDX_BITS  result ROB index.
- cdb_data  out  32  result value.

Function
REQ-005 SHALL buffer requests in an in-order DEPTH-entry FIFO; push when in_valid && in_ready.
REQ-006 SHALL drive in_ready = !full && !flush && !rst; no same-cycle push/pop bypass when full.
REQ-007 SHALL implement FSM states IDLE, START, WAIT, WB, DRAIN.
REQ-008 IDLE, FIFO non-empty: SHALL pop head into the op register. Next state is WB if the op is special (REQ-013/014); otherwise START.
REQ-009 START: SHALL assert div_start for exactly one cycle, then go to WAIT.
REQ-010 WAIT: SHALL capture div_quotient[31:0] (DIV/DIVU) or div_remainder[31:0] (REM/REMU) in the cycle div_complete=1, then go to WB.
REQ-011 div_a/div_b SHALL be registered and held stable from START until the capture cycle. Signed ops sign-extend bit 31 to 33 bits; unsigned ops zero-extend.
REQ-012 WB: SHALL hold cdb_valid=1 with stable cdb_pd/cdb_rob_idx/cdb_data until cdb_ready=1, then go to IDLE. A FIFO pop SHALL NOT occur in that same cycle.
REQ-013 Divisor==0 SHALL bypass the divider (no div_start): DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1.
REQ-014 DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF SHALL bypass the divider: DIV result 0x80000000; REM result 0.
REQ-015 Results SHALL retire in issue order; at most one op in flight.
REQ-016 Minimum latency: push at cycle N, earliest cdb_valid at N+2 for bypass ops; for divider ops, cdb_valid rises 1 cycle after div_complete.
REQ-017 div_complete SHALL be ignored in IDLE, START and WB.
REQ-018 flush SHALL have priority over in_valid and cdb_ready: it empties the FIFO and deasserts cdb_valid next cycle.
REQ-019 flush in IDLE or WB SHALL go to IDLE. Flush in START or WAIT SHALL go to DRAIN.
REQ-020 DRAIN: SHALL wait for div_complete, discard the result, then go to IDLE. New pushes are accepted, but no start is issued while in DRAIN.
REQ-021 Unused funct3 values SHALL be dropped on pop with no CDB broadcast.

Reset
REQ-022 rst SHALL, on the next edge: empty the FIFO, set the FSM to IDLE, and set div_start, cdb_valid, div_a, div_b, cdb_pd, cdb_rob_idx and cdb_data to 0.
REQ-023 in_ready SHALL be 0 while rst=1. It SHALL be 1 in the first cycle after rst deasserts.
REQ-024 rst asserted mid-operation (any state) SHALL abort it. A later div_complete SHALL be ignored.

Verification
REQ-025 DIV rs1=0xFFFFFFF9, rs2=2 -> one div_start pulse, div_a=0x1FFFFFFF9, div_b=0x000000002. Return quotient 0x1FFFFFFFD -> cdb_data=0xFFFFFFFD.
REQ-026 DIVU 7/0 -> no div_start, cdb_data=0xFFFFFFFF. Then REMU 5/0 -> cdb_data=5, in order.
REQ-027 DIV 0x80000000/0xFFFFFFFF -> cdb_data=0x80000000. REM same operands -> 0. No div_start for either.
REQ-028 cdb_ready=0 with back-to-back pushes -> 5 accepted (DEPTH+1), then in_ready=0. Raising cdb_ready retires all 5 in ROB order.
REQ-029 flush during WAIT -> cdb_valid stays 0; next queued op's div_start occurs only after the stale div_complete.
REQ-030 rst during WB -> cdb_valid=0 the next cycle, FIFO empty, in_ready=1 after release.

Source files
------------

// File: rtl/fu_div_issue.sv
// Issue queue and sequencer for a shared multi-cycle divider: buffers RISC-V DIV/REM ops,
// resolves divide-by-zero and signed overflow locally, and broadcasts results in order.
module fu_div_issue #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_rs1_v,
  input  logic [31:0]              in_rs2_v,
  input  logic [2:0]               in_funct3,
  input  logic [PHYS_REG_BITS-1:0] in_pd,
  input  logic [ROB_IDX_BITS-1:0]  in_rob_idx,
  output logic                     div_start,
  output logic [32:0]              div_a,
  output logic [32:0]              div_b,
  input  logic                     div_complete,
  input  logic [32:0]              div_quotient,
  input  logic [32:0]              div_remainder,
  output logic                     cdb_valid,
  input  logic                     cdb_ready,
  output logic [PHYS_REG_BITS-1:0] cdb_pd,
  output logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
  output logic [31:0]              cdb_data
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]              rs1;
    logic [31:0]              rs2;
    logic [2:0]               funct3;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_IDX_BITS-1:0]  rob;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_WB, S_DRAIN} state_t;

  function automatic logic [32:0] extend33(input logic [31:0] v, input logic is_signed);
    return {is_signed & v[31], v};
  endfunction

  // Results the divider is never asked for: x/0 and the single signed overflow case.
  function automatic logic [31:0] special_result(input logic [31:0] rs1, input logic is_rem,
                                                 input logic div_by_zero);
    if (div_by_zero) return is_rem ? rs1 : 32'hFFFF_FFFF;
    return is_rem ? 32'h0 : 32'h8000_0000;
  endfunction

  entry_t                   mem_q [DEPTH];
  entry_t                   mem_d [DEPTH];
  entry_t                   in_entry;
  entry_t                   head;
  logic [PTR_W:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t                   state_q, state_d;
  logic                     div_start_q, div_start_d;
  logic [32:0]              div_a_q, div_a_d, div_b_q, div_b_d;
  logic                     cdb_valid_q, cdb_valid_d;
  logic [PHYS_REG_BITS-1:0] cdb_pd_q, cdb_pd_d;
  logic [ROB_IDX_BITS-1:0]  cdb_rob_idx_q, cdb_rob_idx_d;
  logic [31:0]              cdb_data_q, cdb_data_d;
  logic                     op_rem_q, op_rem_d;
  logic                     full, empty, push, pop;
  logic                     head_signed, head_rem, head_div0, head_ovf;
  logic                     unused_msb;

  assign in_entry   = {in_rs1_v, in_rs2_v, in_funct3, in_pd, in_rob_idx};
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign in_ready   = !full && !flush && !rst;
  assign push       = in_valid && in_ready;
  assign unused_msb = ^{div_quotient[32], div_remainder[32]};

  always_comb begin
    head        = mem_q[rd_ptr_q[PTR_W-1:0]];
    head_signed = !head.funct3[0];
    head_rem    = head.funct3[1];
    head_div0   = (head.rs2 == 32'h0);
    head_ovf    = head_signed && (head.rs1 == 32'h8000_0000) && (head.rs2 == 32'hFFFF_FFFF);

    state_d       = state_q;
    pop           = 1'b0;
    div_start_d   = 1'b0;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_pd_d      = cdb_pd_q;
    cdb_rob_idx_d = cdb_rob_idx_q;
    cdb_data_d    = cdb_data_q;
    op_rem_d      = op_rem_q;

    if (flush) begin
      cdb_valid_d = 1'b0;
      // A started divide must still finish before the divider may be reused.
      case (state_q)
        S_START: state_d = S_DRAIN;
        S_WAIT:  state_d = div_complete ? S_IDLE : S_DRAIN;
        S_DRAIN: state_d = div_complete ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop = 1'b1;
            if (head.funct3[2]) begin
              cdb_pd_d      = head.pd;
              cdb_rob_idx_d = head.rob;
              op_rem_d      = head_rem;
              if (head_div0 || head_ovf) begin
                cdb_data_d  = special_result(head.rs1, head_rem, head_div0);
                cdb_valid_d = 1'b1;
                state_d     = S_WB;
              end else begin
                div_a_d     = extend33(head.rs1, head_signed);
                div_b_d     = extend33(head.rs2, head_signed);
                div_start_d = 1'b1;
                state_d     = S_START;
              end
            end
          end
        end
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (div_complete) begin
            cdb_data_d  = op_rem_q ? div_remainder[31:0] : div_quotient[31:0];
            cdb_valid_d = 1'b1;
            state_d     = S_WB;
          end
        end
        S_WB: begin
          if (cdb_ready) begin
            cdb_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        S_DRAIN: if (div_complete) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
    if (push) mem_d[wr_ptr_q[PTR_W-1:0]] = in_entry;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Stage boundary: queue storage (payload only, no reset needed)
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Stage boundary: control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      div_start_q   <= 1'b0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_pd_q      <= '0;
      cdb_rob_idx_q <= '0;
      cdb_data_q    <= '0;
      op_rem_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      div_start_q   <= div_start_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_pd_q      <= cdb_pd_d;
      cdb_rob_idx_q <= cdb_rob_idx_d;
      cdb_data_q    <= cdb_data_d;
      op_rem_q      <= op_rem_d;
    end
  end

  assign div_start   = div_start_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign cdb_valid   = cdb_valid_q;
  assign cdb_pd      = cdb_pd_q;
  assign cdb_rob_idx = cdb_rob_idx_q;
  assign cdb_data    = cdb_data_q;
endmodule

// File: tb/tb_fu_div_issue.sv
// Bench for fu_div_issue: behavioural divider responder plus an in-order result scoreboard.
module tb_fu_div_issue;
  localparam int DIV_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_rs1_v = '0;
  logic [31:0] in_rs2_v = '0;
  logic [2:0]  in_funct3 = '0;
  logic [5:0]  in_pd = '0;
  logic [4:0]  in_rob_idx = '0;
  logic        div_start;
  logic [32:0] div_a, div_b;
  logic        div_complete = 1'b0;
  logic [32:0] div_quotient = '0;
  logic [32:0] div_remainder = '0;
  logic        cdb_valid;
  logic        cdb_ready = 1'b0;
  logic [5:0]  cdb_pd;
  logic [4:0]  cdb_rob_idx;
  logic [31:0] cdb_data;

  fu_div_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_v(in_rs1_v), .in_rs2_v(in_rs2_v), .in_funct3(in_funct3), .in_pd(in_pd),
    .in_rob_idx(in_rob_idx), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_complete(div_complete), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_pd(cdb_pd), .cdb_rob_idx(cdb_rob_idx),
    .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  pd;
    logic [4:0]  rob;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          start_while_busy = 0;
  int          ab_moved = 0;
  bit          busy = 1'b0;
  bit          prev_start = 1'b0;
  int          cnt = 0;
  logic [32:0] lat_a = '0;
  logic [32:0] lat_b = '0;

  always @(posedge clk) cyc++;

  // RISC-V M-extension reference for one op.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sd;
    logic               ovf;
    sa  = a;
    sd  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sd);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sd);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divider responder: completes DIV_LAT cycles after each start.
  always @(negedge clk) begin
    logic signed [32:0] na, nd;
    div_complete = 1'b0;
    if (div_start) begin
      start_cnt++;
      if (busy) start_while_busy++;
      lat_a = div_a;
      lat_b = div_b;
      busy  = 1'b1;
      cnt   = DIV_LAT;
    end else if (busy) begin
      if (div_a !== lat_a || div_b !== lat_b) ab_moved++;
      cnt--;
      if (cnt == 0) begin
        na = lat_a;
        nd = lat_b;
        busy = 1'b0;
        div_complete  = 1'b1;
        div_quotient  = (nd == 0) ? '1 : 33'(na / nd);
        div_remainder = (nd == 0) ? lat_a : 33'(na % nd);
      end
    end
    prev_start = div_start;
  end

  // Scoreboard: every accepted broadcast is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && cdb_valid && cdb_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL cdb_unexpected: got data=%h rob=%0d, required no broadcast",
                 cdb_data, cdb_rob_idx);
      end else begin
        mon_e = sb.pop_front();
        if (cdb_data !== mon_e.data || cdb_pd !== mon_e.pd || cdb_rob_idx !== mon_e.rob) begin
          bad++;
          $display("FAIL cdb_result: got data=%h pd=%0d rob=%0d, required data=%h pd=%0d rob=%0d",
                   cdb_data, cdb_pd, cdb_rob_idx, mon_e.data, mon_e.pd, mon_e.rob);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic push_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] pd, input logic [4:0] rob);
    int t = 0;
    exp_t e;
    in_valid = 1'b1;
    in_funct3 = f;
    in_rs1_v = a;
    in_rs2_v = b;
    in_pd = pd;
    in_rob_idx = rob;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
    end else if (f[2]) begin
      e.data = ref_result(f, a, b);
      e.pd = pd;
      e.rob = rob;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 300);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b, required 1", in_ready); end
    total++;
    if ({cdb_valid, div_start} !== 2'b00) begin
      bad++; $display("FAIL rst_ctrl: got valid=%b start=%b, required 0 0", cdb_valid, div_start);
    end
    total++;
    if (div_a !== 33'h0 || div_b !== 33'h0) begin
      bad++; $display("FAIL rst_div_ab: got a=%h b=%h, required 0 0", div_a, div_b);
    end
    total++;
    if (cdb_data !== 32'h0 || cdb_pd !== 6'h0 || cdb_rob_idx !== 5'h0) begin
      bad++; $display("FAIL rst_cdb: got data=%h pd=%h rob=%h, required 0", cdb_data, cdb_pd, cdb_rob_idx);
    end
  endtask

  task automatic test_div_signed();
    int s0 = start_cnt;
    int t = 0;
    bit ok;
    cdb_ready = 1'b1;
    sync();
    push_op(3'b100, 32'hFFFF_FFF9, 32'd2, 6'd3, 5'd1);
    do begin @(posedge clk); t++; end while (div_complete !== 1'b1 && t < 100);
    @(negedge clk);
    total++;
    if (cdb_valid !== 1'b1) begin bad++; $display("FAIL div_lat: cdb_valid=%b after complete, required 1", cdb_valid); end
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL div_drain: pending=%0d, required 0", sb.size()); end
    total++;
    if (lat_a !== 33'h1_FFFF_FFF9 || lat_b !== 33'h0_0000_0002) begin
      bad++; $display("FAIL div_operands: got a=%h b=%h, required 1fffffff9 000000002", lat_a, lat_b);
    end
    total++;
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL div_starts: got %0d, required 1", start_cnt - s0); end
  endtask

  task automatic test_bypass();
    int s0 = start_cnt;
    bit ok;
    cdb_ready = 1'b1;
    sync();
    push_op(3'b101, 32'd7, 32'd0, 6'd4, 5'd2);
    @(negedge clk);
    total++;
    if (cdb_valid !== 1'b0) begin bad++; $display("FAIL byp_lat1: cdb_valid=%b, required 0", cdb_valid); end
    @(negedge clk);
    total++;
    if (cdb_valid !== 1'b1) begin bad++; $display("FAIL byp_lat2: cdb_valid=%b, required 1", cdb_valid); end
    sync();
    push_op(3'b111, 32'd5, 32'd0, 6'd5, 5'd3);
    push_op(3'b000, 32'd9, 32'd3, 6'd6, 5'd4);
    push_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd7, 5'd5);
    push_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 5'd6);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL byp_drain: pending=%0d, required 0", sb.size()); end
    total++;
    if (start_cnt != s0) begin bad++; $display("FAIL byp_starts: got %0d, required 0", start_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    int s0 = start_cnt;
    int c0;
    logic [31:0] d0;
    logic [4:0] r0;
    bit ok;
    cdb_ready = 1'b0;
    sync();
    c0 = cyc;
    push_op(3'b101, 32'd100, 32'd7, 6'd10, 5'd10);
    push_op(3'b110, 32'hFFFF_FF9C, 32'd7, 6'd11, 5'd11);
    push_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 5'd12);
    push_op(3'b111, 32'd9, 32'd0, 6'd13, 5'd13);
    push_op(3'b100, 32'd50, 32'hFFFF_FFFB, 6'd14, 5'd14);
    total++;
    if (cyc - c0 != 5) begin bad++; $display("FAIL b2b_accept: took %0d cycles, required 5", cyc - c0); end
    in_valid = 1'b1;
    in_funct3 = 3'b101;
    in_rs1_v = 32'd1;
    in_rs2_v = 32'd1;
    repeat (DIV_LAT + 6) @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: in_ready=%b, required 0", in_ready); end
    total++;
    if (cdb_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold_valid: cdb_valid=%b, required 1", cdb_valid); end
    d0 = cdb_data;
    r0 = cdb_rob_idx;
    repeat (3) @(negedge clk);
    total++;
    if (cdb_valid !== 1'b1 || cdb_data !== d0 || cdb_rob_idx !== r0) begin
      bad++; $display("FAIL b2b_stable: got v=%b data=%h rob=%0d, required 1 %h %0d", cdb_valid, cdb_data, cdb_rob_idx, d0, r0);
    end
    in_valid = 1'b0;
    cdb_ready = 1'b1;
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_drain: pending=%0d, required 0", sb.size()); end
    total++;
    if (start_cnt - s0 != 3) begin bad++; $display("FAIL b2b_starts: got %0d, required 3", start_cnt - s0); end
    total++;
    if (ab_moved != 0) begin bad++; $display("FAIL div_ab_stable: moved %0d times, required 0", ab_moved); end
  endtask

  task automatic test_flush();
    int s0;
    int swb0 = start_while_busy;
    int t = 0;
    bit ok;
    cdb_ready = 1'b0;
    sync();
    push_op(3'b111, 32'd5, 32'd0, 6'd20, 5'd20);
    push_op(3'b101, 32'd7, 32'd0, 6'd21, 5'd21);
    @(negedge clk);
    total++;
    if (cdb_valid !== 1'b1) begin bad++; $display("FAIL fl_pre_valid: cdb_valid=%b, required 1", cdb_valid); end
    sync();
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready: got %b, required 0", in_ready); end
    @(posedge clk);
    #1 flush = 1'b0;
    sb.delete();
    @(negedge clk);
    total++;
    if (cdb_valid !== 1'b0) begin bad++; $display("FAIL fl_valid_drop: cdb_valid=%b, required 0", cdb_valid); end
    cdb_ready = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (cdb_valid !== 1'b0) begin bad++; $display("FAIL fl_fifo_empty: cdb_valid=%b, required 0", cdb_valid); end

    s0 = start_cnt;
    sync();
    push_op(3'b101, 32'd1000, 32'd3, 6'd22, 5'd22);
    while (div_start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    sb.delete();
    push_op(3'b100, 32'd20, 32'd3, 6'd23, 5'd23);
    @(negedge clk);
    total++;
    if (cdb_valid !== 1'b0) begin bad++; $display("FAIL fl_wait_valid: cdb_valid=%b, required 0", cdb_valid); end
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fl_drain: pending=%0d, required 0", sb.size()); end
    total++;
    if (start_while_busy != swb0) begin
      bad++; $display("FAIL fl_start_early: %0d starts before stale completion, required 0", start_while_busy - swb0);
    end
    total++;
    if (start_cnt - s0 != 2) begin bad++; $display("FAIL fl_starts: got %0d, required 2", start_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int seen = 0;
    int swb0 = start_while_busy;
    bit ok;
    cdb_ready = 1'b0;
    sync();
    push_op(3'b111, 32'd5, 32'd0, 6'd30, 5'd30);
    push_op(3'b101, 32'd7, 32'd0, 6'd31, 5'd31);
    @(negedge clk);
    total++;
    if (cdb_valid !== 1'b1) begin bad++; $display("FAIL rwb_pre_valid: cdb_valid=%b, required 1", cdb_valid); end
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rwb_in_ready: got %b, required 0", in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    total++;
    if (cdb_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rwb_after: got valid=%b ready=%b, required 0 1", cdb_valid, in_ready);
    end
    cdb_ready = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rwb_fifo_empty: cdb_valid=%b, required 0", cdb_valid); end

    sync();
    push_op(3'b101, 32'd1000, 32'd3, 6'd32, 5'd1);
    while (div_start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    t = 0;
    while ((busy || t < 3) && t < 50) begin
      @(negedge clk);
      if (cdb_valid) seen++;
      t++;
    end
    repeat (3) begin @(negedge clk); if (cdb_valid) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rwait_stale: cdb_valid seen %0d cycles, required 0", seen); end
    ab_moved = 0;
    sync();
    push_op(3'b100, 32'd20, 32'd3, 6'd33, 5'd2);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rwait_recover: pending=%0d, required 0", sb.size()); end
    total++;
    if (start_while_busy != swb0) begin
      bad++; $display("FAIL rwait_start_busy: got %0d, required 0", start_while_busy - swb0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_div_signed();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
